seg_595_scan_ctrl: RTL
======================

Name: seg_595_scan_ctrl

Overview:
Dynamic-scan scheduler for the 6-digit segment display behind the 74HC595 chain.
- Holds six 8-bit segment codes and time-multiplexes them, one digit per scan slot.
- For each digit, serialises a 14-bit word (segment + one-hot select) onto ds/shcp, then pulses stcp.
- Sits between the number/decode logic and the 595 pins; it replaces the single static-pattern driver.

Parameters:
CNT_SCAN_MAX, 50_000, clocks per digit slot (1 ms at 50 MHz); must be >= 64; testbenches override to 100.
DIG_NUM, 6, number of digits and select width; fixed at 6 in this revision.

Ports:
sys_clk      input   1   system clock, 50 MHz
sys_rst      input   1   synchronous, active-high reset
seg_data     input   48  digit k code = seg_data[8k+7:8k], passed to segments unchanged
data_vld     input   1   1-clk strobe; captures seg_data into shadow register
ds           output  1   595 serial data
shcp         output  1   595 shift clock
stcp         output  1   595 storage (latch) clock
oe           output  1   595 output enable, active-low
frame_done   output  1   1-clk pulse when digit 5 latch completes

Behaviour:
- Clock and reset: single clock sys_clk; reset is synchronous and active-high (sys_rst).
- Reset values: ds=0, shcp=0, stcp=0, oe=1, frame_done=0, shadow=0, active=0, digit index=0, scan counter=0, state=IDLE.
- Reset asserted mid-frame takes priority: all registers return to reset values on that edge; no partial stcp.
- Shadow capture: data_vld=1 loads seg_data into shadow in the same edge.
- Active copy: shadow is copied into the active register only when digit index wraps to 0, at the start of a frame. There is no mid-frame tearing.
- If data_vld and the frame-start copy coincide, the new seg_data goes straight into active.
- Scan counter: counts 0..CNT_SCAN_MAX-1, restarts at 0 on every SHIFT entry; one digit slot = CNT_SCAN_MAX clocks exactly.
- Shift word: W = {sel[5:0], seg[7:0]}, with sel one-hot active-high (sel[k]=1 for digit k) and seg = active code for digit k.
- Shift order: W[13] first, W[0] last; 14 bits.
- Bit timing, 4 clocks per bit, phases 0-3:
  - ds changes only at phase 0.
  - shcp=0 in phases 0-1 and 1 in phases 2-3.
  - A SHIFT therefore lasts 56 clocks; shcp idles at 0 outside SHIFT.
- FSM:
  - IDLE: one clock after reset release -> SHIFT (digit 0, frame copy performed).
  - SHIFT: after the 14th bit's phase 3 -> LATCH.
  - LATCH: stcp=1 for 2 clocks, ds held; oe goes 0 on the first LATCH ever and stays 0 until reset. Then -> WAIT.
  - WAIT: when scan counter = CNT_SCAN_MAX-1, digit index increments (wraps 5->0) -> SHIFT.
- frame_done: asserted for one clock on the last LATCH clock of digit 5.
- Latency: data_vld to pins is at most one full frame (6*CNT_SCAN_MAX) plus 58 clocks.

Optional Feature:
SEG_595_DIG_MASK_EN
- Defined: adds input dig_en[5:0], sampled at each digit-index advance.
  - Digits with dig_en[k]=0 are skipped: no SHIFT and no slot time, so the next enabled digit starts immediately.
  - Wrap detection and the shadow copy occur on passing index 0.
  - If dig_en==0, the FSM parks in WAIT with oe=1 and no shcp/stcp activity.
  - It resumes at the lowest enabled digit the clock after dig_en becomes nonzero.
  - frame_done pulses after the highest enabled digit latches.
- Not defined: port absent; all 6 digits scanned in order 0..5.

Test Plan:
- Reset, then release with CNT_SCAN_MAX=100 and seg_data=0 -> oe=1 until the first stcp; first stcp rises on clock 58 after IDLE; digit slots start exactly 100 clocks apart.
- data_vld with digit0=8'hC0, digit1=8'hF9 -> sampling ds at shcp rising edges gives digit0 word 14'b000001_11000000 and digit1 word 14'b000010_11111001, MSB first.
- data_vld pulsed mid-frame (during digit 3) -> digits 3-5 still show the old codes; new codes appear from digit 0 of the next frame; frame_done pulses once per 600 clocks.
- sys_rst asserted during the 7th bit of SHIFT -> next edge: ds=shcp=stcp=0, oe=1; no stcp seen; scan restarts at digit 0 one clock after release.
- SEG_595_DIG_MASK_EN with dig_en=6'b100101 -> only digits 0, 2, 5 shifted; frame_done every 300 clocks; setting dig_en=0 gives no shcp edges and oe=1.

Source files
------------

// File: rtl/seg_595_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_595_scan_ctrl
// Brief    : Six-digit dynamic-scan scheduler driving a 74HC595 chain. Each
//            slot shifts {one-hot select, segment code} MSB first, then
//            latches it. Optional macro SEG_595_DIG_MASK_EN adds dig_en.
// Revision : 1.0 - initial release
// ============================================================================
module seg_595_scan_ctrl #(
    parameter int CNT_SCAN_MAX = 50_000,
    parameter int DIG_NUM      = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [8*DIG_NUM-1:0] seg_data,
    input  logic                 data_vld,
`ifdef SEG_595_DIG_MASK_EN
    input  logic [DIG_NUM-1:0]   dig_en,
`endif
    output logic                 ds,
    output logic                 shcp,
    output logic                 stcp,
    output logic                 oe,
    output logic                 frame_done
);

    localparam int              c_CW        = $clog2(CNT_SCAN_MAX);
    localparam int              c_WW        = DIG_NUM + 8;
    localparam logic [c_CW-1:0] c_SHIFT_END = c_CW'(4 * c_WW - 1);
    localparam logic [c_CW-1:0] c_LATCH_END = c_CW'(4 * c_WW + 1);
    localparam logic [c_CW-1:0] c_SLOT_END  = c_CW'(CNT_SCAN_MAX - 1);
    localparam logic [2:0]      c_LAST_DIG  = 3'(DIG_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_CW-1:0]        r_cnt_q, w_cnt_d;
    logic [2:0]             r_dig_q, w_dig_d;
    logic [8*DIG_NUM-1:0]   r_shadow_q, w_shadow_d;
    logic [8*DIG_NUM-1:0]   r_active_q, w_active_d;
    logic                   r_ds_q, w_ds_d;
    logic                   r_shcp_q, w_shcp_d;
    logic                   r_stcp_q, w_stcp_d;
    logic                   r_oe_q, w_oe_d;
    logic                   r_frame_done_q, w_frame_done_d;
    logic                   w_frame_start;
    logic                   w_park_d;
    logic [2:0]             w_last_dig;
    logic [DIG_NUM-1:0]     w_sel;
    logic [c_WW-1:0]        w_word;
    logic [3:0]             w_bit;

`ifdef SEG_595_DIG_MASK_EN
    logic       r_park_q;
    logic       w_en_any;
    logic       w_en_wrap;
    logic [2:0] w_en_low;
    logic [2:0] w_en_high;
    logic [2:0] w_en_next;

    // Descending scans leave the lowest qualifying index in the result.
    always_comb begin
        w_en_any  = |dig_en;
        w_en_low  = 3'd0;
        w_en_high = 3'd0;
        w_en_next = 3'd0;
        w_en_wrap = 1'b1;
        for (int k = DIG_NUM - 1; k >= 0; k--) begin
            if (dig_en[k]) w_en_low = 3'(k);
        end
        for (int k = 0; k < DIG_NUM; k++) begin
            if (dig_en[k]) w_en_high = 3'(k);
        end
        w_en_next = w_en_low;
        for (int k = DIG_NUM - 1; k >= 0; k--) begin
            if (dig_en[k] && (3'(k) > r_dig_q)) begin
                w_en_next = 3'(k);
                w_en_wrap = 1'b0;
            end
        end
    end

    assign w_last_dig = w_en_high;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_park_q <= 1'b0;
        else         r_park_q <= w_park_d;
    end
`else
    assign w_last_dig = c_LAST_DIG;
`endif

    // Next-state logic; active is refreshed only at a frame start so a frame never tears.
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_dig_d       = r_dig_q;
        w_frame_start = 1'b0;
`ifdef SEG_595_DIG_MASK_EN
        w_park_d      = r_park_q;
`else
        w_park_d      = 1'b0;
`endif
        w_shadow_d    = data_vld ? seg_data : r_shadow_q;
        unique case (r_state_q)
            ST_IDLE: begin
`ifdef SEG_595_DIG_MASK_EN
                if (w_en_any) begin
                    w_state_d     = ST_SHIFT;
                    w_dig_d       = w_en_low;
                    w_cnt_d       = '0;
                    w_frame_start = 1'b1;
                end else begin
                    w_state_d = ST_WAIT;
                    w_park_d  = 1'b1;
                end
`else
                w_state_d     = ST_SHIFT;
                w_dig_d       = 3'd0;
                w_cnt_d       = '0;
                w_frame_start = 1'b1;
`endif
            end
            ST_SHIFT: begin
                w_cnt_d = r_cnt_q + c_CW'(1);
                if (r_cnt_q == c_SHIFT_END) w_state_d = ST_LATCH;
            end
            ST_LATCH: begin
                w_cnt_d = r_cnt_q + c_CW'(1);
                if (r_cnt_q == c_LATCH_END) w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef SEG_595_DIG_MASK_EN
                if (r_park_q) begin
                    if (w_en_any) begin
                        w_state_d     = ST_SHIFT;
                        w_dig_d       = w_en_low;
                        w_cnt_d       = '0;
                        w_frame_start = 1'b1;
                        w_park_d      = 1'b0;
                    end
                end else if (r_cnt_q == c_SLOT_END) begin
                    if (w_en_any) begin
                        w_state_d     = ST_SHIFT;
                        w_dig_d       = w_en_next;
                        w_cnt_d       = '0;
                        w_frame_start = w_en_wrap;
                    end else begin
                        w_park_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
`else
                if (r_cnt_q == c_SLOT_END) begin
                    w_state_d     = ST_SHIFT;
                    w_cnt_d       = '0;
                    w_dig_d       = (r_dig_q == c_LAST_DIG) ? 3'd0 : r_dig_q + 3'd1;
                    w_frame_start = (r_dig_q == c_LAST_DIG);
                end else begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
`endif
            end
            default: w_state_d = ST_IDLE;
        endcase
        w_active_d = w_frame_start ? w_shadow_d : r_active_q;
    end

    // Pin values are derived from next-state so they register alongside the FSM.
    always_comb begin
        w_sel          = DIG_NUM'(1) << w_dig_d;
        w_word         = {w_sel, w_active_d[{w_dig_d, 3'b000} +: 8]};
        w_bit          = 4'(c_WW - 1) - w_cnt_d[5:2];
        w_ds_d         = (w_state_d == ST_SHIFT) ? w_word[w_bit] : r_ds_q;
        w_shcp_d       = (w_state_d == ST_SHIFT) && w_cnt_d[1];
        w_stcp_d       = (w_state_d == ST_LATCH);
        w_frame_done_d = (w_state_d == ST_LATCH) && (w_cnt_d == c_LATCH_END) &&
                         (w_dig_d == w_last_dig);
        w_oe_d         = r_oe_q;
        if (w_park_d)                    w_oe_d = 1'b1;
        else if (w_state_d == ST_LATCH)  w_oe_d = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_dig_q        <= 3'd0;
            r_shadow_q     <= '0;
            r_active_q     <= '0;
            r_ds_q         <= 1'b0;
            r_shcp_q       <= 1'b0;
            r_stcp_q       <= 1'b0;
            r_oe_q         <= 1'b1;
            r_frame_done_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_dig_q        <= w_dig_d;
            r_shadow_q     <= w_shadow_d;
            r_active_q     <= w_active_d;
            r_ds_q         <= w_ds_d;
            r_shcp_q       <= w_shcp_d;
            r_stcp_q       <= w_stcp_d;
            r_oe_q         <= w_oe_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    assign ds         = r_ds_q;
    assign shcp       = r_shcp_q;
    assign stcp       = r_stcp_q;
    assign oe         = r_oe_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire
